// File: rtl/ffm_inverter_if.sv
// Multiplier request/response bus between the field inverter and the ffm.
// The inverter drives operands and start; the multiplier returns the reduced product.
interface ffm_inverter_if;
    logic         mul_start;
    logic [254:0] mul_a;
    logic [254:0] mul_b;
    logic [254:0] mul_result;
    logic         mul_valid;

    modport master (
        output mul_start, mul_a, mul_b,
        input  mul_result, mul_valid
    );

    modport slave (
        input  mul_start, mul_a, mul_b,
        output mul_result, mul_valid
    );
endinterface

// File: rtl/ffm_inverter.sv
// GF(2^255-19) inverter: a^EXP by left-to-right square-and-multiply,
// issuing each square/multiply to an external ffm over the mul bus.
module ffm_inverter #(
    parameter logic [254:0] EXP     = {255{1'b1}} - 255'd20,
    parameter int           EXP_MSB = 254
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [254:0]   a,
    output logic [254:0]   result,
    output logic           valid,
    output logic           busy,
    ffm_inverter_if.master mul
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SQ_WAIT  = 2'd1;
    localparam logic [1:0] MUL_WAIT = 2'd2;

    localparam logic [7:0] IDX_START = (EXP_MSB > 0) ? 8'(EXP_MSB - 1) : 8'd0;

    logic [1:0]   state_q, state_d;
    logic [7:0]   idx_q, idx_d;
    logic [254:0] base_q, base_d;
    logic [254:0] result_q, result_d;
    logic [254:0] mul_a_q, mul_a_d;
    logic [254:0] mul_b_q, mul_b_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         mul_start_q, mul_start_d;
    logic         finish;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        result_d    = result_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        mul_start_d = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (EXP_MSB == 0) begin
                        result_d = a;
                        valid_d  = 1'b1;
                    end else begin
                        base_d      = a;
                        mul_a_d     = a;
                        mul_b_d     = a;
                        mul_start_d = 1'b1;
                        busy_d      = 1'b1;
                        idx_d       = IDX_START;
                        state_d     = SQ_WAIT;
                    end
                end
            end
            SQ_WAIT: begin
                if (mul.mul_valid) begin
                    if (EXP[idx_q]) begin
                        mul_a_d     = mul.mul_result;
                        mul_b_d     = base_q;
                        mul_start_d = 1'b1;
                        state_d     = MUL_WAIT;
                    end else if (idx_q == 8'd0) begin
                        finish = 1'b1;
                    end else begin
                        idx_d       = idx_q - 8'd1;
                        mul_a_d     = mul.mul_result;
                        mul_b_d     = mul.mul_result;
                        mul_start_d = 1'b1;
                    end
                end
            end
            MUL_WAIT: begin
                if (mul.mul_valid) begin
                    if (idx_q == 8'd0) begin
                        finish = 1'b1;
                    end else begin
                        idx_d       = idx_q - 8'd1;
                        mul_a_d     = mul.mul_result;
                        mul_b_d     = mul.mul_result;
                        mul_start_d = 1'b1;
                        state_d     = SQ_WAIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion is shared by both wait states: the last product is the answer.
        if (finish) begin
            result_d = mul.mul_result;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= 8'd0;
            base_q      <= '0;
            result_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            result_q    <= result_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
        end
    end

    assign result        = result_q;
    assign valid         = valid_q;
    assign busy          = busy_q;
    assign mul.mul_start = mul_start_q;
    assign mul.mul_a     = mul_a_q;
    assign mul.mul_b     = mul_b_q;

endmodule

// File: tb/tb_ffm_inverter.sv
// Bench for ffm_inverter: behavioural ffm stand-in, cycle-level reference model
// of busy/valid/mul_start/result, and directed plus randomized inversions.
module tb_ffm_inverter;

    localparam int L        = 2;
    localparam int N_OPS    = 506;
    localparam int OP_CYC   = N_OPS * (L + 1);
    localparam int DONE_CYC = OP_CYC + 1;

    localparam logic [254:0] P    = {255{1'b1}} - 255'd18;
    localparam logic [254:0] EXP  = P - 255'd2;
    localparam logic [254:0] INV2 = (255'd1 << 254) - 255'd9;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [254:0] a_in  = '0;
    logic [254:0] result;
    logic         valid;
    logic         busy;

    ffm_inverter_if mbus ();

    ffm_inverter #(.EXP(EXP), .EXP_MSB(254)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a_in),
        .result (result),
        .valid  (valid),
        .busy   (busy),
        .mul    (mbus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [254:0] got, input logic [254:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
        logic [511:0] p;
        p = {257'd0, x} * {257'd0, y};
        return 255'(p % {257'd0, P});
    endfunction

    // Right-to-left binary exponentiation: independent of the DUT's bit order.
    function automatic logic [254:0] modexp(input logic [254:0] x);
        logic [254:0] r = 255'd1;
        logic [254:0] b = x;
        for (int i = 0; i < 255; i++) begin
            if (EXP[i]) r = mulmod(r, b);
            b = mulmod(b, b);
        end
        return r;
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        r[255] = 1'b0;
        if (r[254:0] >= P) r = r - {1'b0, P};
        if (r[254:0] == '0) r[0] = 1'b1;
        return r[254:0];
    endfunction

    // ffm stand-in: start in cycle c gives valid in cycle c+L.
    logic [L-1:0] pipe_v;
    logic [254:0] pipe_p [L];
    logic         spur_v = 1'b0;
    logic [254:0] spur_r = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v <= '0;
            for (int i = 0; i < L; i++) pipe_p[i] <= '0;
        end else begin
            pipe_v <= {pipe_v[L-2:0], mbus.mul_start};
            pipe_p[0] <= mbus.mul_start ? mulmod(mbus.mul_a, mbus.mul_b) : '0;
            for (int i = 1; i < L; i++) pipe_p[i] <= pipe_p[i-1];
        end
    end

    assign mbus.mul_valid  = pipe_v[L-1] | spur_v;
    assign mbus.mul_result = spur_v ? spur_r : pipe_p[L-1];

    // Reference model: timing from the operation count, value from modexp.
    logic         m_busy, m_valid, m_mstart;
    logic [254:0] m_result, m_pend;
    int           m_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_mstart <= 1'b0;
            m_result <= '0;
            m_pend   <= '0;
            m_cnt    <= 0;
        end else begin
            m_valid  <= 1'b0;
            m_mstart <= 1'b0;
            if (m_busy) begin
                if (m_cnt + 1 == OP_CYC) begin
                    m_busy   <= 1'b0;
                    m_valid  <= 1'b1;
                    m_result <= m_pend;
                end else if ((m_cnt + 1) % (L + 1) == 0) begin
                    m_mstart <= 1'b1;
                end
                m_cnt <= m_cnt + 1;
            end else if (start) begin
                m_busy   <= 1'b1;
                m_mstart <= 1'b1;
                m_cnt    <= 0;
                m_pend   <= modexp(a_in);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("busy", busy, m_busy);
            check("valid", valid, m_valid);
            check("mul_start", mbus.mul_start, m_mstart);
            if (valid || m_valid) check("result", result, m_result);
        end
    end

    int ms_cnt = 0;
    int valid_cnt = 0;
    always @(negedge clk) begin
        if (mbus.mul_start) ms_cnt++;
        if (valid) valid_cnt++;
    end

    // Caller is at a negedge; start is sampled on the following posedge.
    task automatic launch(input logic [254:0] av);
        start = 1'b1;
        a_in  = av;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = rand255();
    endtask

    task automatic wait_done(input string name, input int k0, output logic [254:0] res);
        bit found = 0;
        int lat = 0;
        res = '0;
        for (int k = k0 + 1; k <= DONE_CYC + 20 && !found; k++) begin
            @(negedge clk);
            if (valid) begin
                found = 1;
                lat   = k;
                res   = result;
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no valid within %0d cycles", name, DONE_CYC + 20);
        end else begin
            check({name, "_latency"}, 255'(lat), 255'(DONE_CYC));
        end
    endtask

    initial begin
        logic [254:0] res, av, av_prev, a1;

        #23;
        check("rst_result", result, '0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mul_start", mbus.mul_start, 1'b0);
        check("rst_mul_a", mbus.mul_a, '0);
        check("rst_mul_b", mbus.mul_b, '0);
        @(negedge clk);
        rst = 1'b1;

        check("model_inv2", modexp(255'd2), INV2);
        check("model_pm1", modexp(P - 255'd1), P - 255'd1);
        check("model_zero", modexp(255'd0), 255'd0);

        // Stray multiplier response while idle must change nothing.
        @(negedge clk);
        spur_v = 1'b1;
        spur_r = rand255();
        @(negedge clk);
        spur_v = 1'b0;
        @(negedge clk);
        check("idle_mulvalid_result", result, '0);

        valid_cnt = 0;
        launch(255'd1);
        wait_done("a1", 0, res);
        check("a1_result", res, 255'd1);
        repeat (5) @(negedge clk);
        check("a1_valid_pulses", 255'(valid_cnt), 255'd1);

        launch(255'd2);
        wait_done("a2", 0, res);
        check("a2_result", res, INV2);
        check("a2_product", mulmod(255'd2, res), 255'd1);

        launch(255'd0);
        wait_done("a0", 0, res);
        check("a0_result", res, 255'd0);

        launch(P - 255'd1);
        wait_done("apm1", 0, res);
        check("apm1_result", res, P - 255'd1);

        // Back-to-back random operands, each start issued in the previous valid cycle.
        av = rand255();
        launch(av);
        for (int i = 0; i < 20; i++) begin
            av_prev = av;
            wait_done("rand", 0, res);
            if (i < 19) begin
                av = rand255();
                launch(av);
            end
            check("rand_result", res, modexp(av_prev));
            check("rand_product", mulmod(av_prev, res), 255'd1);
        end

        // Start with a different operand while busy must be ignored.
        @(negedge clk);
        ms_cnt = 0;
        a1 = rand255();
        launch(a1);
        repeat (50) @(negedge clk);
        start = 1'b1;
        a_in  = rand255();
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 51, res);
        check("busy_start_result", res, modexp(a1));
        @(negedge clk);
        check("busy_start_mul_ops", 255'(ms_cnt), 255'(N_OPS));

        // Reset in the middle of operation 200.
        ms_cnt = 0;
        launch(rand255());
        for (int k = 0; k < OP_CYC && ms_cnt < 200; k++) @(negedge clk);
        check("rst_reach_op200", 255'(ms_cnt), 255'd200);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", valid, 1'b0);
        check("midrst_mul_start", mbus.mul_start, 1'b0);
        check("midrst_result", result, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        launch(255'd2);
        wait_done("post_rst_a2", 0, res);
        check("post_rst_a2_result", res, INV2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
